// File: rtl/transmit_if.sv
// transmit_if: byte-load handshake and serial frame outputs of the transmitter
// master drives DataIn/Load and observes Ready/StartOp/SerData/Busy; slave is the transmitter side
interface transmit_if;
  logic [7:0] DataIn;
  logic       Load;
  logic       Ready;
  logic       StartOp;
  logic       SerData;
  logic       Busy;
  modport master (output DataIn, Load, input Ready, StartOp, SerData, Busy);
  modport slave (input DataIn, Load, output Ready, StartOp, SerData, Busy);
endinterface

// File: rtl/transmit.sv
// transmit: serial frame transmitter (START strobe, SYNC low, 8 data bits LSB first, STOP high)
// Ports: Clk, Reset (synchronous, active-high); tx (transmit_if.slave): DataIn/Load in, Ready/StartOp/SerData/Busy out
// Option: define TRANSMIT_BUFFER_EN to add a one-byte holding register for back-to-back frames
module transmit (
  input logic       Clk,
  input logic       Reset,
  transmit_if.slave tx
);
  typedef enum logic [3:0] {
    IDLE, START, SYNC, BIT_0, BIT_1, BIT_2, BIT_3, BIT_4, BIT_5, BIT_6, BIT_7, STOP
  } state_t;
  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx;
  logic       accept;
`ifdef TRANSMIT_BUFFER_EN
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;
  assign tx.Ready = !full_q;
`else
  assign tx.Ready = state_q == IDLE;
`endif
  assign accept     = tx.Load && tx.Ready;
  // data states are contiguous, so the bit number is the offset from BIT_0
  assign bit_idx    = 3'(4'(state_q) - 4'(BIT_0));
  assign tx.Busy    = state_q != IDLE;
  assign tx.StartOp = state_q == START;
  assign tx.SerData = state_q == SYNC ? 1'b0 :
                      (state_q >= BIT_0 && state_q <= BIT_7) ? shift_q[bit_idx] : 1'b1;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
`ifdef TRANSMIT_BUFFER_EN
    hold_d  = hold_q;
    full_d  = full_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = tx.DataIn;
        end
      end
      STOP: begin
        state_d = IDLE;
`ifdef TRANSMIT_BUFFER_EN
        // a full holding reg cannot coincide with an accept, since Ready = !full
        if (full_q) begin
          state_d = START;
          shift_d = hold_q;
          full_d  = 1'b0;
        end else if (accept) begin
          state_d = START;
          shift_d = tx.DataIn;
        end
`endif
      end
      default: begin
        state_d = state_t'(4'(state_q) + 4'd1);
`ifdef TRANSMIT_BUFFER_EN
        if (accept) begin
          hold_d = tx.DataIn;
          full_d = 1'b1;
        end
`endif
      end
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      shift_q <= '0;
`ifdef TRANSMIT_BUFFER_EN
      hold_q  <= '0;
      full_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
`ifdef TRANSMIT_BUFFER_EN
      hold_q  <= hold_d;
      full_q  <= full_d;
`endif
    end
  end
endmodule

// File: tb/tb_transmit.sv
// tb_transmit: randomized scoreboard bench for transmit with a frame-counter reference model
module tb_transmit;
`ifdef TRANSMIT_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  transmit_if tx();
  transmit dut (.Clk(Clk), .Reset(Reset), .tx(tx));
  always #5 Clk = ~Clk;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_q[$];
  logic [7:0] byte_q[$];
  int         left = 0;
  logic       pend = 1'b0;
  logic [7:0] hold = '0;
  logic [7:0] cur = '0;
  logic       acc_last = 1'b0;

  // Model: a frame is 11 cycles; left counts the cycles of the frame still to be shown.
  initial forever begin
    logic       rdy, ld, ser;
    int         p;
    @(posedge Clk);
    acc_last = 1'b0;
    if (Reset) begin
      left = 0;
      pend = 1'b0;
      byte_q.delete();
    end else begin
      rdy = BUF_EN ? !pend : (left == 0);
      ld  = tx.Load && rdy;
      acc_last = ld;
      if (left == 0) begin
        if (ld) begin cur = tx.DataIn; left = 11; byte_q.push_back(tx.DataIn); end
      end else if (left == 1) begin
        if (pend) begin cur = hold; pend = 1'b0; left = 11; byte_q.push_back(hold); end
        else if (ld) begin cur = tx.DataIn; left = 11; byte_q.push_back(tx.DataIn); end
        else left = 0;
      end else begin
        if (ld) begin pend = 1'b1; hold = tx.DataIn; end
        left = left - 1;
      end
    end
    p   = 11 - left;
    ser = (left == 0 || p == 0 || p == 10) ? 1'b1 : (p == 1) ? 1'b0 : cur[p-2];
    exp_q.push_back({BUF_EN ? !pend : (left == 0), left != 0, left == 11, ser});
  end

  // Monitor: per-cycle output compare plus a receiver that rebuilds each framed byte.
  initial begin
    logic       cap = 1'b0;
    int         cnt = 0;
    logic [7:0] rx = '0;
    logic [7:0] eb = '0;
    logic [3:0] e, got;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {tx.Ready, tx.Busy, tx.StartOp, tx.SerData};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL outputs t=%0t {Ready,Busy,StartOp,SerData} got=%b exp=%b", $time, got, e);
        end
      end
      if (cap) begin
        if (!tx.Busy) cap = 1'b0;
        else begin
          cnt++;
          if (cnt >= 2) rx = {tx.SerData, rx[7:1]};
          if (cnt == 9) begin
            cap = 1'b0;
            checks++;
            if (rx !== eb) begin
              failures++;
              $display("FAIL rx_byte t=%0t got=%h exp=%h", $time, rx, eb);
            end
          end
        end
      end
      if (tx.StartOp === 1'b1) begin
        checks++;
        if (byte_q.size() == 0) begin
          failures++;
          $display("FAIL startop t=%0t got=unexpected StartOp exp=no frame", $time);
        end else begin
          eb  = byte_q.pop_front();
          cap = 1'b1;
          cnt = 0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    tx.Load = 1'b1;
    tx.DataIn = b;
    do begin @(negedge Clk); n++; end while (!acc_last && n < 50);
    checks++;
    if (!acc_last) begin
      failures++;
      $display("FAIL send_timeout t=%0t got=not accepted exp=accepted byte %h", $time, b);
    end
    tx.Load = 1'b0;
    tx.DataIn = 8'($urandom);
  endtask

  initial begin
    tx.Load = 1'b0;
    tx.DataIn = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    send(8'hA5);
    repeat (14) @(negedge Clk);
    send(8'h00);
    send(8'hFF);
    send(8'h3C);
    repeat (14) @(negedge Clk);
    send(8'h5A);
    repeat (5) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (15) @(negedge Clk);
    send(8'h77);
    repeat (4) @(negedge Clk);
    tx.Load = 1'b1;
    tx.DataIn = 8'h11;
    @(negedge Clk);
    tx.Load = 1'b0;
    repeat (14) @(negedge Clk);
    send(8'h12);
    repeat (2) @(negedge Clk);
    tx.Load = 1'b1;
    tx.DataIn = 8'h34;
    @(negedge Clk);
    tx.DataIn = 8'h56;
    @(negedge Clk);
    tx.Load = 1'b0;
    repeat (30) @(negedge Clk);
    for (int i = 0; i < 600; i++) begin
      Reset = ($urandom_range(0, 149) == 0);
      tx.Load = ($urandom_range(0, 2) == 0);
      tx.DataIn = 8'($urandom);
      @(negedge Clk);
    end
    Reset = 1'b0;
    tx.Load = 1'b0;
    repeat (30) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
